// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, default memory-wait
// limit and bit positions of the stage-register stall/flush controls.
package hazard_unit_pkg;

   typedef enum logic {
      StRun     = 1'b0,
      StMemWait = 1'b1
   } hz_state_e;

   localparam int unsigned WaitMaxDefault = 255;

   // Stall control bit positions (registers that can be held)
   localparam int unsigned StallPc    = 0;
   localparam int unsigned StallIfId  = 1;
   localparam int unsigned StallIdEx  = 2;
   localparam int unsigned StallExMem = 3;
   localparam int unsigned NumStall   = 4;

   // Flush control bit positions (registers that can take a bubble)
   localparam int unsigned FlushIfId  = 0;
   localparam int unsigned FlushIdEx  = 1;
   localparam int unsigned FlushMemWb = 2;
   localparam int unsigned NumFlush   = 3;

   typedef logic [NumStall-1:0] stall_vec_t;
   typedef logic [NumFlush-1:0] flush_vec_t;

   // A source read depends on the EX destination; x0 never creates a dependency.
   function automatic logic src_hit(logic [4:0] ra, logic re, logic [4:0] wa);
      return re && (ra == wa) && (wa != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   // Count up on inc, holding once every bit is set
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: memory freeze, branch flush and load-use stall with
// fixed priority, a memory-wait timeout monitor and saturating event counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WAIT_MAX = WaitMaxDefault
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       rf_ra0_id,
   input  logic [4:0]       rf_ra1_id,
   input  logic             rf_re0_id,
   input  logic             rf_re1_id,
   input  logic             mem_re_ex,
   input  logic [4:0]       rf_wa_ex,
   input  logic             br_taken_ex,
   input  logic             dmem_req_mem,
   input  logic             dmem_ready,
   output logic             stall_pc,
   output logic             stall_if_id,
   output logic             stall_id_ex,
   output logic             stall_ex_mem,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_mem_wb,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   hz_state_e   state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic        mem_timeout_q;

   logic        mem_freeze;
   logic        load_use;
   stall_vec_t  stall_vec;
   flush_vec_t  flush_vec;

   assign mem_freeze = dmem_req_mem && !dmem_ready;
   assign load_use   = mem_re_ex &&
                       (src_hit(rf_ra0_id, rf_re0_id, rf_wa_ex) ||
                        src_hit(rf_ra1_id, rf_re1_id, rf_wa_ex));

   // Prioritised hazard decode; lower-priority events are dropped, not queued
   always_comb begin
      stall_vec = '0;
      flush_vec = '0;
      if (mem_freeze) begin
         stall_vec[StallPc]    = 1'b1;
         stall_vec[StallIfId]  = 1'b1;
         stall_vec[StallIdEx]  = 1'b1;
         stall_vec[StallExMem] = 1'b1;
         flush_vec[FlushMemWb] = 1'b1;
      end else if (br_taken_ex) begin
         flush_vec[FlushIfId]  = 1'b1;
         flush_vec[FlushIdEx]  = 1'b1;
      end else if (load_use) begin
         stall_vec[StallPc]    = 1'b1;
         stall_vec[StallIfId]  = 1'b1;
         flush_vec[FlushIdEx]  = 1'b1;
      end
   end

   assign stall_pc     = stall_vec[StallPc];
   assign stall_if_id  = stall_vec[StallIfId];
   assign stall_id_ex  = stall_vec[StallIdEx];
   assign stall_ex_mem = stall_vec[StallExMem];
   assign flush_if_id  = flush_vec[FlushIfId];
   assign flush_id_ex  = flush_vec[FlushIdEx];
   assign flush_mem_wb = flush_vec[FlushMemWb];

   // Memory-wait FSM with wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= StRun;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mem_freeze) begin
                  state_q    <= StMemWait;
                  wait_cnt_q <= '0;
               end
            end
            StMemWait: begin
               if (wait_cnt_q != WAIT_W'(WAIT_MAX)) begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
               // Flag on the cycle that brings the count up to the limit
               if ((32'(wait_cnt_q) + 32'd1) >= WAIT_MAX) begin
                  mem_timeout_q <= 1'b1;
               end
               if (dmem_ready) begin
                  state_q <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assign mem_timeout = mem_timeout_q;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (stall_pc),
      .count (stall_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (flush_if_id || flush_id_ex),
      .count (flush_cnt)
   );

endmodule
